// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - coin-operated vending controller: credit, vend handshake, change return
//
// Purpose: accumulates coin credit, sells one item at PRICE, returns change
// one unit per cycle, refunds on cancel or after TIMEOUT idle cycles in CREDIT.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   coin_valid   in   one-cycle coin strobe
//   coin_val     in   [1:0] coin value code: 00=1, 01=2, 10=5, 11=10
//   sel          in   one-cycle purchase request
//   cancel       in   one-cycle refund request
//   disp_ack     in   dispenser done acknowledge
//   disp_req     out  dispense request, held until acknowledged
//   cs           out  [3:0] current credit
//   fd           out  one-cycle item-delivered pulse
//   change_pulse out  one-cycle pulse per credit unit returned
//   coin_reject  out  one-cycle pulse, coin returned unaccepted
//   busy         out  high while vending or returning change

module vend_ctrl #(
    parameter logic [3:0] PRICE   = 4'd8,
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       sel,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic [3:0] cs,
    output logic       fd,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_credit;
    logic [7:0] r_idle_cnt;
    logic       r_disp_req;
    logic       r_fd;
    logic       r_change_pulse;
    logic       r_coin_reject;
    logic       r_busy;

    logic [3:0] w_coin_units;
    logic [4:0] w_sum;
    logic       w_coin_fits;

    always_comb begin
        w_coin_units = 4'd1;
        case (coin_val)
            2'b00:   w_coin_units = 4'd1;
            2'b01:   w_coin_units = 4'd2;
            2'b10:   w_coin_units = 4'd5;
            default: w_coin_units = 4'd10;
        endcase
    end

    // One extra bit so an overflowing coin is detected instead of wrapping.
    assign w_sum       = {1'b0, r_credit} + {1'b0, w_coin_units};
    assign w_coin_fits = ~w_sum[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= 4'd0;
            r_idle_cnt     <= 8'd0;
            r_disp_req     <= 1'b0;
            r_fd           <= 1'b0;
            r_change_pulse <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_fd           <= 1'b0;
            r_change_pulse <= 1'b0;
            r_coin_reject  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Credit is zero here, so any single coin fits.
                    if (coin_valid) begin
                        r_credit   <= w_coin_units;
                        r_idle_cnt <= 8'd0;
                        r_state    <= S_CREDIT;
                    end
                end
                S_CREDIT: begin
                    if (cancel) begin
                        r_state       <= S_CHANGE;
                        r_busy        <= 1'b1;
                        r_coin_reject <= coin_valid;
                    end else if (sel && (r_credit >= PRICE)) begin
                        r_credit      <= r_credit - PRICE;
                        r_state       <= S_VEND;
                        r_disp_req    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_coin_reject <= coin_valid;
                    end else if (coin_valid && w_coin_fits) begin
                        r_credit   <= w_sum[3:0];
                        r_idle_cnt <= 8'd0;
                    end else begin
                        r_coin_reject <= coin_valid;
                        // A short-credit sel counts as activity; a rejected coin does not.
                        if (sel) begin
                            r_idle_cnt <= 8'd0;
                        end else if (r_idle_cnt == TIMEOUT - 8'd1) begin
                            r_state <= S_CHANGE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 8'd1;
                        end
                    end
                end
                S_VEND: begin
                    r_coin_reject <= coin_valid;
                    if (disp_ack) begin
                        r_disp_req <= 1'b0;
                        r_fd       <= 1'b1;
                        if (r_credit != 4'd0) begin
                            r_state <= S_CHANGE;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_CHANGE: begin
                    r_coin_reject <= coin_valid;
                    if (r_credit != 4'd0) begin
                        r_credit       <= r_credit - 4'd1;
                        r_change_pulse <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign disp_req     = r_disp_req;
    assign cs           = r_credit;
    assign fd           = r_fd;
    assign change_pulse = r_change_pulse;
    assign coin_reject  = r_coin_reject;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed self-checking bench for vend_ctrl

module tb_vend_ctrl;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       sel;
    logic       cancel;
    logic       disp_ack;
    logic       disp_req;
    logic [3:0] cs;
    logic       fd;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;

    vend_ctrl #(.PRICE(4'd8), .TIMEOUT(8'd200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .sel          (sel),
        .cancel       (cancel),
        .disp_ack     (disp_ack),
        .disp_req     (disp_req),
        .cs           (cs),
        .fd           (fd),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        step();
        coin_valid = 1'b0;
    endtask

    // Steps until busy drops (bounded), counting change pulses seen.
    task automatic drain(input string tag, input int exp_pulses);
        int cnt;
        int k;
        cnt = 0;
        k = 0;
        while (busy && k < 20) begin
            step();
            if (change_pulse) cnt++;
            k++;
        end
        chk({tag, "_pulses"}, 8'(cnt), 8'(exp_pulses));
        chk({tag, "_idle"}, {7'd0, busy}, 8'd0);
        chk({tag, "_cs0"}, {4'd0, cs}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; coin_valid = 1'b0; coin_val = 2'b00;
        sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0;
        step(); step();
        chk("rst_cs", {4'd0, cs}, 8'd0);
        chk("rst_disp_req", {7'd0, disp_req}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_pulses", {5'd0, fd, change_pulse, coin_reject}, 8'd0);
        rst_n = 1'b1;

        // Basic purchase with exact credit
        coin(2'b10); chk("a_cs5", {4'd0, cs}, 8'd5);
        coin(2'b01); chk("a_cs7", {4'd0, cs}, 8'd7);
        coin(2'b00); chk("a_cs8", {4'd0, cs}, 8'd8);
        sel = 1'b1; step(); sel = 1'b0;
        chk("a_sel_cs", {4'd0, cs}, 8'd0);
        chk("a_disp_req", {7'd0, disp_req}, 8'd1);
        chk("a_busy", {7'd0, busy}, 8'd1);
        step(); step();
        chk("a_disp_req_held", {7'd0, disp_req}, 8'd1);
        disp_ack = 1'b1; step(); disp_ack = 1'b0;
        chk("a_disp_req_drop", {7'd0, disp_req}, 8'd0);
        chk("a_fd", {7'd0, fd}, 8'd1);
        chk("a_idle", {7'd0, busy}, 8'd0);
        step();
        chk("a_fd_one", {7'd0, fd}, 8'd0);
        chk("a_no_change", {7'd0, change_pulse}, 8'd0);

        // disp_ack outside VEND has no effect
        disp_ack = 1'b1; step(); disp_ack = 1'b0;
        chk("ack_idle_fd", {7'd0, fd}, 8'd0);
        chk("ack_idle_busy", {7'd0, busy}, 8'd0);

        // Purchase with change
        coin(2'b11); chk("b_cs10", {4'd0, cs}, 8'd10);
        coin(2'b00); chk("b_cs11", {4'd0, cs}, 8'd11);
        sel = 1'b1; step(); sel = 1'b0;
        chk("b_cs3", {4'd0, cs}, 8'd3);
        chk("b_disp_req", {7'd0, disp_req}, 8'd1);
        disp_ack = 1'b1; step(); disp_ack = 1'b0;
        chk("b_fd", {7'd0, fd}, 8'd1);
        chk("b_busy", {7'd0, busy}, 8'd1);
        chk("b_no_pulse_yet", {7'd0, change_pulse}, 8'd0);
        step(); chk("b_cp1", {3'd0, change_pulse, cs}, 8'h12);
        step(); chk("b_cp2", {3'd0, change_pulse, cs}, 8'h11);
        step(); chk("b_cp3", {3'd0, change_pulse, cs}, 8'h10);
        step();
        chk("b_end_pulse", {7'd0, change_pulse}, 8'd0);
        chk("b_end_idle", {7'd0, busy}, 8'd0);

        // Overflow reject and coin during VEND
        coin(2'b11); coin(2'b10);
        chk("c_cs15", {4'd0, cs}, 8'd15);
        coin(2'b00);
        chk("c_reject", {7'd0, coin_reject}, 8'd1);
        chk("c_cs_hold", {4'd0, cs}, 8'd15);
        step();
        chk("c_reject_one", {7'd0, coin_reject}, 8'd0);
        sel = 1'b1; step(); sel = 1'b0;
        chk("c_cs7", {4'd0, cs}, 8'd7);
        coin(2'b00);
        chk("c_vend_reject", {7'd0, coin_reject}, 8'd1);
        chk("c_vend_cs", {4'd0, cs}, 8'd7);
        chk("c_vend_req", {7'd0, disp_req}, 8'd1);
        disp_ack = 1'b1; step(); disp_ack = 1'b0;
        chk("c_fd", {7'd0, fd}, 8'd1);
        drain("c", 7);

        // Short-credit sel ignored; cancel wins over sel and coin
        coin(2'b10);
        sel = 1'b1; step(); sel = 1'b0;
        chk("d_sel_ign_cs", {4'd0, cs}, 8'd5);
        chk("d_sel_ign_req", {7'd0, disp_req}, 8'd0);
        chk("d_sel_ign_busy", {7'd0, busy}, 8'd0);
        cancel = 1'b1; sel = 1'b1; coin_valid = 1'b1; coin_val = 2'b00;
        step();
        cancel = 1'b0; sel = 1'b0; coin_valid = 1'b0;
        chk("d_cancel_busy", {7'd0, busy}, 8'd1);
        chk("d_cancel_reject", {7'd0, coin_reject}, 8'd1);
        chk("d_cancel_cs", {4'd0, cs}, 8'd5);
        drain("d", 5);

        // Timeout refund: CHANGE entered on the TIMEOUT-th idle cycle
        coin(2'b01);
        chk("e_cs2", {4'd0, cs}, 8'd2);
        for (int i = 0; i < 199; i++) step();
        chk("e_not_yet", {7'd0, busy}, 8'd0);
        chk("e_cs_hold", {4'd0, cs}, 8'd2);
        step();
        chk("e_timeout", {7'd0, busy}, 8'd1);
        drain("e", 2);

        // Asynchronous reset mid-VEND
        coin(2'b11);
        sel = 1'b1; step(); sel = 1'b0;
        chk("f_disp_req", {7'd0, disp_req}, 8'd1);
        chk("f_cs2", {4'd0, cs}, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("f_rst_req", {7'd0, disp_req}, 8'd0);
        chk("f_rst_cs", {4'd0, cs}, 8'd0);
        chk("f_rst_busy", {7'd0, busy}, 8'd0);
        #1 rst_n = 1'b1;
        coin(2'b01);
        chk("f_first_edge", {4'd0, cs}, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 4'd8, item price in credit units; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 8'd200, idle cycles in CREDIT before automatic refund; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 coin_valid  input  1  one-cycle strobe, coin inserted.
REQ-006 coin_val  input  2  coin value: 00=1, 01=2, 10=5, 11=10 units.
REQ-007 sel  input  1  one-cycle strobe, purchase request.
REQ-008 cancel  input  1  one-cycle strobe, refund request.
REQ-009 disp_ack  input  1  dispenser done acknowledge.
REQ-010 disp_req  output  1  dispense request to dispenser.
REQ-011 cs  output  4  current credit, feeds output logic.
REQ-012 fd  output  1  one-cycle item-delivered pulse.
REQ-013 change_pulse  output  1  one-cycle pulse, one credit unit returned.
REQ-014 coin_reject  output  1  one-cycle pulse, coin returned unaccepted.
REQ-015 busy  output  1  high in VEND or CHANGE.

Function
REQ-016 FSM states SHALL be IDLE, CREDIT, VEND, CHANGE; all outputs registered.
REQ-017 IDLE: credit=0; accepted coin_valid -> credit=coin value, go CREDIT.
REQ-018 Coin accepted in IDLE/CREDIT only if credit+value <= 15, else coin_reject pulses next cycle and credit is unchanged (no wrap).
REQ-019 Coin_valid in VEND or CHANGE SHALL be rejected (coin_reject pulse, credit unchanged).
REQ-020 CREDIT priority per cycle: cancel > sel > coin > timeout.
REQ-021 CREDIT, cancel: go CHANGE; same-cycle coin rejected.
REQ-022 CREDIT, sel with credit >= PRICE: credit -= PRICE, go VEND, disp_req=1 next cycle; same-cycle coin rejected.
REQ-023 CREDIT, sel with credit < PRICE: sel ignored; same-cycle coin processed normally.
REQ-024 Idle counter resets on any accepted coin or ignored sel; reaching TIMEOUT cycles in CREDIT -> CHANGE.
REQ-025 VEND: disp_req held high until disp_ack sampled high; that cycle disp_req drops, fd pulses one cycle next edge.
REQ-026 After ack: credit>0 -> CHANGE, credit=0 -> IDLE; disp_ack outside VEND ignored.
REQ-027 CHANGE: each cycle credit decrements by 1 with one change_pulse; at credit=0 go IDLE, no pulse at 0.
REQ-028 cancel and sel ignored in VEND and CHANGE.
REQ-029 cs SHALL equal credit register at all times; busy=1 exactly in VEND/CHANGE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, credit=0, idle counter=0, and all outputs 0, including mid-VEND (disp_req dropped) or mid-CHANGE (remaining credit discarded).
REQ-031 First state update SHALL occur on the first rising clk after rst_n deasserts.

Verification
REQ-032 Reset, coins 5,2,1 (PRICE=8) -> cs 5,7,8; sel -> cs=0, disp_req=1; disp_ack after 3 cycles -> fd one pulse, state IDLE, no change_pulse.
REQ-033 Coins 10,1 then sel -> cs=3, disp_req; ack -> fd, then exactly 3 change_pulse on consecutive cycles, cs 2,1,0, IDLE.
REQ-034 Coins 10,5 (cs=15) then coin 1 -> coin_reject pulse, cs=15; coin during VEND -> coin_reject, cs unchanged.
REQ-035 cs=5, sel -> ignored, cs=5; cancel+sel+coin same cycle -> CHANGE, coin_reject, 5 change_pulses.
REQ-036 cs=2, no activity TIMEOUT cycles -> CHANGE, 2 change_pulses; rst_n low during VEND -> disp_req=0, cs=0 immediately.
